// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types for the reorder buffer: default tag width, the entry-kind
// encoding (NORMAL / BRANCH / STORE), the per-entry payload record, and a
// helper that classifies an issuing instruction into an entry kind.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

    // Tag width; the buffer depth is 2**ROB_ADDR_W_DEFAULT entries.
    localparam int ROB_ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ENTRY_NORMAL = 2'd0,
        ENTRY_BRANCH = 2'd1,
        ENTRY_STORE  = 2'd2
    } entry_kind_e;

    // Payload of one entry. busy/ready live in separate flop vectors so that a
    // flush can clear them in one edge without touching this array.
    typedef struct packed {
        logic [4:0]  rd;
        entry_kind_e kind;
        logic        pred_taken;
        logic [31:0] pc;
        logic [31:0] val;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

    // A store never writes a register and a branch never stores, so a store
    // flag takes precedence if both are ever raised.
    function automatic entry_kind_e classify_entry(input logic is_branch,
                                                   input logic is_store);
        if (is_store) begin
            return ENTRY_STORE;
        end
        if (is_branch) begin
            return ENTRY_BRANCH;
        end
        return ENTRY_NORMAL;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order retirement buffer for the Tomasulo core.
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   rdy                 global enable; low freezes every piece of state
//   issue_*             dispatcher allocation; issue_tag returns the tail index
//   rob_full            registered count equals depth
//   query_Q*/R*/V*      operand lookup with same-cycle bus forwarding
//   alu_* / lsb_*       write-back buses
//   commit_*            register-file commit and store release (pulses)
//   rollback*           mispredict flush and fetch redirect (pulse)
//   bp_*                branch predictor update (pulse)
// -----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ADDR_W = ROB_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_is_branch,
    input  logic                  issue_is_store,
    input  logic                  issue_pred_taken,
    input  logic [31:0]           issue_pc,
    output logic [ROB_ADDR_W-1:0] issue_tag,
    output logic                  rob_full,
    input  logic [ROB_ADDR_W-1:0] query_Qj,
    input  logic [ROB_ADDR_W-1:0] query_Qk,
    output logic                  query_Rj,
    output logic                  query_Rk,
    output logic [31:0]           query_Vj,
    output logic [31:0]           query_Vk,
    input  logic                  alu_valid,
    input  logic [ROB_ADDR_W-1:0] alu_tag,
    input  logic [31:0]           alu_val,
    input  logic                  alu_taken,
    input  logic [31:0]           alu_target,
    input  logic                  lsb_valid,
    input  logic [ROB_ADDR_W-1:0] lsb_tag,
    input  logic [31:0]           lsb_val,
    output logic                  commit_valid,
    output logic [4:0]            commit_rd,
    output logic [ROB_ADDR_W-1:0] commit_tag,
    output logic [31:0]           commit_val,
    output logic                  commit_store,
    output logic                  rollback,
    output logic [31:0]           rollback_pc,
    output logic                  bp_update,
    output logic [31:0]           bp_pc,
    output logic                  bp_taken
);

    localparam int ROB_SIZE = 1 << ROB_ADDR_W;

    typedef logic [ROB_ADDR_W-1:0] tag_t;
    typedef logic [ROB_ADDR_W:0]   cnt_t;

    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    tag_t                head_q, head_d;
    tag_t                tail_q, tail_d;
    cnt_t                count_q, count_d;
    rob_entry_t          entry_q [ROB_SIZE];

    rob_entry_t head_entry;
    logic       accept_issue;
    logic       alu_wr;
    logic       lsb_wr;
    logic       do_commit;
    logic       mispredict;
    logic       flush;

    assign head_entry = entry_q[head_q];
    assign rob_full   = (count_q == cnt_t'(ROB_SIZE));
    assign issue_tag  = tail_q;

    // While the rollback pulse is visible the rest of the core is still
    // draining wrong-path work, so allocations and bus writes are dropped.
    assign accept_issue = rdy && issue_valid && !rob_full && !rollback;
    assign alu_wr       = rdy && alu_valid && !rollback;
    assign lsb_wr       = rdy && lsb_valid && !rollback;

    // Retirement only looks at registered ready, which gives the one-cycle
    // write-back-to-commit latency.
    assign do_commit  = rdy && busy_q[head_q] && ready_q[head_q];
    assign mispredict = (head_entry.kind == ENTRY_BRANCH) &&
                        (head_entry.taken != head_entry.pred_taken);
    assign flush      = do_commit && mispredict;

    // ---------------------------------------------------------------- queries
    tag_t        q_tag [2];
    logic        q_rdy [2];
    logic [31:0] q_val [2];

    assign q_tag[0] = query_Qj;
    assign q_tag[1] = query_Qk;
    assign query_Rj = q_rdy[0];
    assign query_Rk = q_rdy[1];
    assign query_Vj = q_val[0];
    assign query_Vk = q_val[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            logic alu_match;
            logic lsb_match;
            logic stored;

            assign alu_match = alu_valid && (alu_tag == q_tag[gi]);
            assign lsb_match = lsb_valid && (lsb_tag == q_tag[gi]);
            assign stored    = ready_q[q_tag[gi]];
            assign q_rdy[gi] = stored || alu_match || lsb_match;
            assign q_val[gi] = stored    ? entry_q[q_tag[gi]].val :
                               alu_match ? alu_val :
                               lsb_match ? lsb_val : 32'd0;
        end
    endgenerate

    // ------------------------------------------------------- control next state
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + cnt_t'(accept_issue) - cnt_t'(do_commit);

        if (accept_issue) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + tag_t'(1);
        end
        if (alu_wr) begin
            ready_d[alu_tag] = 1'b1;
        end
        if (lsb_wr) begin
            ready_d[lsb_tag] = 1'b1;
        end
        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + tag_t'(1);
        end
        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload array carries no reset: an entry is only ever read after it has
    // been allocated, and busy/ready decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept_issue) begin
            entry_q[tail_q] <= '{rd:         issue_rd,
                                 kind:       classify_entry(issue_is_branch, issue_is_store),
                                 pred_taken: issue_pred_taken,
                                 pc:         issue_pc,
                                 val:        32'd0,
                                 taken:      1'b0,
                                 target:     32'd0};
        end
        if (alu_wr) begin
            entry_q[alu_tag].val    <= alu_val;
            entry_q[alu_tag].taken  <= alu_taken;
            entry_q[alu_tag].target <= alu_target;
        end
        if (lsb_wr) begin
            entry_q[lsb_tag].val <= lsb_val;
        end
    end

    // ------------------------------------------------------- retirement outputs
    // Pulses drop every edge they are not re-armed; the data fields hold their
    // last retired value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_tag   <= '0;
            commit_val   <= '0;
            commit_store <= 1'b0;
            rollback     <= 1'b0;
            rollback_pc  <= '0;
            bp_update    <= 1'b0;
            bp_pc        <= '0;
            bp_taken     <= 1'b0;
        end else begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            rollback     <= 1'b0;
            bp_update    <= 1'b0;
            if (do_commit) begin
                commit_tag <= head_q;
                // A jalr is a branch with a link register, so only stores are
                // excluded from the register-file write.
                if (head_entry.rd != 5'd0 && head_entry.kind != ENTRY_STORE) begin
                    commit_valid <= 1'b1;
                    commit_rd    <= head_entry.rd;
                    commit_val   <= head_entry.val;
                end
                if (head_entry.kind == ENTRY_STORE) begin
                    commit_store <= 1'b1;
                end
                if (head_entry.kind == ENTRY_BRANCH) begin
                    bp_update <= 1'b1;
                    bp_pc     <= head_entry.pc;
                    bp_taken  <= head_entry.taken;
                end
                if (mispredict) begin
                    rollback    <= 1'b1;
                    rollback_pc <= head_entry.target;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Scoreboard bench for reorder_buffer: every issued instruction that should
// retire pushes its expected retirement record; a negedge monitor pops and
// compares whenever the DUT raises a retirement pulse.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_is_branch;
    logic        issue_is_store;
    logic        issue_pred_taken;
    logic [31:0] issue_pc;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic [3:0]  query_Qj, query_Qk;
    logic        query_Rj, query_Rk;
    logic [31:0] query_Vj, query_Vk;
    logic        alu_valid;
    logic [3:0]  alu_tag;
    logic [31:0] alu_val;
    logic        alu_taken;
    logic [31:0] alu_target;
    logic        lsb_valid;
    logic [3:0]  lsb_tag;
    logic [31:0] lsb_val;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_val;
    logic        commit_store;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        bp_update;
    logic [31:0] bp_pc;
    logic        bp_taken;

    reorder_buffer #(.ROB_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_branch(issue_is_branch), .issue_is_store(issue_is_store),
        .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
        .issue_tag(issue_tag), .rob_full(rob_full),
        .query_Qj(query_Qj), .query_Qk(query_Qk),
        .query_Rj(query_Rj), .query_Rk(query_Rk),
        .query_Vj(query_Vj), .query_Vk(query_Vk),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val),
        .alu_taken(alu_taken), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_tag(commit_tag), .commit_val(commit_val),
        .commit_store(commit_store),
        .rollback(rollback), .rollback_pc(rollback_pc),
        .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic        cs;
        logic        bp;
        logic        rb;
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
        logic        bpt;
        logic [31:0] bppc;
        logic [31:0] rbpc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wb_val   [16];
    logic        wb_taken [16];
    logic [31:0] wb_tgt   [16];
    int          exp_tail;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic br, input logic st,
                            input logic pred, input logic [31:0] pc, input logic [31:0] val,
                            input logic taken, input logic [31:0] tgt, input bit expect_commit);
        exp_t e;
        issue_valid      = 1'b1;
        issue_rd         = rd;
        issue_is_branch  = br;
        issue_is_store   = st;
        issue_pred_taken = pred;
        issue_pc         = pc;
        #1;
        check("issue_tag", 32'(issue_tag), 32'(exp_tail));
        e.cv   = (rd != 5'd0) && !st;
        e.cs   = st;
        e.bp   = br;
        e.rb   = br && (taken != pred);
        e.rd   = rd;
        e.tag  = 4'(exp_tail);
        e.val  = val;
        e.bpt  = taken;
        e.bppc = pc;
        e.rbpc = tgt;
        if (expect_commit) exp_q.push_back(e);
        wb_val[exp_tail]   = val;
        wb_taken[exp_tail] = taken;
        wb_tgt[exp_tail]   = tgt;
        exp_tail = (exp_tail + 1) % 16;
        step();
        issue_valid = 1'b0;
        $display("issue tag=%0d rd=%0d br=%0b st=%0b val=0x%08h", e.tag, rd, br, st, val);
    endtask

    task automatic writeback(input bit ua, input int ta, input bit ul, input int tl);
        alu_valid  = ua;
        alu_tag    = 4'(ta);
        alu_val    = wb_val[ta];
        alu_taken  = wb_taken[ta];
        alu_target = wb_tgt[ta];
        lsb_valid  = ul;
        lsb_tag    = 4'(tl);
        lsb_val    = wb_val[tl];
        step();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_tail = 0;
    endtask

    // Retirement monitor.
    always @(negedge clk) begin
        if (!rst && (commit_valid || commit_store || bp_update || rollback)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit",
                      32'({commit_valid, commit_store, bp_update, rollback}), 32'd0);
            end else begin : pop_blk
                exp_t e;
                e = exp_q.pop_front();
                $display("retire tag=%0d cv=%0b rd=%0d val=0x%08h st=%0b bp=%0b rb=%0b",
                         commit_tag, commit_valid, commit_rd, commit_val,
                         commit_store, bp_update, rollback);
                check("commit_tag",   32'(commit_tag),   32'(e.tag));
                check("commit_valid", 32'(commit_valid), 32'(e.cv));
                check("commit_store", 32'(commit_store), 32'(e.cs));
                check("bp_update",    32'(bp_update),    32'(e.bp));
                check("rollback",     32'(rollback),     32'(e.rb));
                if (e.cv) begin
                    check("commit_rd",  32'(commit_rd), 32'(e.rd));
                    check("commit_val", commit_val,     e.val);
                end
                if (e.bp) begin
                    check("bp_pc",    bp_pc,          e.bppc);
                    check("bp_taken", 32'(bp_taken), 32'(e.bpt));
                end
                if (e.rb) check("rollback_pc", rollback_pc, e.rbpc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        issue_valid = 0; issue_rd = 0; issue_is_branch = 0; issue_is_store = 0;
        issue_pred_taken = 0; issue_pc = 0;
        query_Qj = 0; query_Qk = 0;
        alu_valid = 0; alu_tag = 0; alu_val = 0; alu_taken = 0; alu_target = 0;
        lsb_valid = 0; lsb_tag = 0; lsb_val = 0;
        exp_tail = 0;
        for (int i = 0; i < 16; i++) begin
            wb_val[i] = 0; wb_taken[i] = 0; wb_tgt[i] = 0;
        end
        step();
        step();
        check("rst_issue_tag",    32'(issue_tag),    32'd0);
        check("rst_rob_full",     32'(rob_full),     32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_commit_store", 32'(commit_store), 32'd0);
        check("rst_rollback",     32'(rollback),     32'd0);
        check("rst_bp_update",    32'(bp_update),    32'd0);
        rst = 1'b0;
        step();

        // Single add: issue, write back, retire one cycle later.
        do_issue(5'd5, 0, 0, 0, 32'h100, 32'h2A, 0, 0, 1);
        writeback(1, 0, 0, 0);
        step();
        check("t2_rob_full", 32'(rob_full), 32'd0);
        wait_drain(10);

        // Fill to 16, refuse the 17th, refuse issue at full even with a commit.
        for (int i = 0; i < 16; i++)
            do_issue(5'(i + 1), 0, 0, 0, 32'(32'h400 + 4 * i), 32'(32'h100 + i), 0, 0, 1);
        #1 check("full_set", 32'(rob_full), 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd31;
        step();
        issue_valid = 1'b0;
        #1 check("full_tail_held", 32'(issue_tag), 32'(exp_tail));
        check("full_still", 32'(rob_full), 32'd1);
        writeback(1, exp_tail, 0, 0);
        issue_valid = 1'b1; issue_rd = 5'd31;
        step();
        issue_valid = 1'b0;
        #1 check("full_refuse_tail", 32'(issue_tag), 32'(exp_tail));
        check("after_commit_not_full", 32'(rob_full), 32'd0);
        writeback(1, (exp_tail + 1) % 16, 0, 0);
        do_issue(5'd20, 0, 0, 0, 32'h500, 32'h500, 0, 0, 1);
        #1 check("issue_and_commit_count", 32'(rob_full), 32'd0);
        do_issue(5'd21, 0, 0, 0, 32'h504, 32'h600, 0, 0, 1);
        #1 check("refill_full", 32'(rob_full), 32'd1);
        for (int i = 7; i >= 0; i--)
            writeback(1, (exp_tail + 2 * i) % 16, 1, (exp_tail + 2 * i + 1) % 16);
        wait_drain(60);

        // Reset with five entries outstanding and the head ready.
        for (int i = 0; i < 6; i++)
            do_issue(5'(i + 1), 0, 0, 0, 32'h600, 32'(32'h30 + i), 0, 0, 1);
        writeback(1, (exp_tail + 10) % 16, 1, (exp_tail + 11) % 16);
        step();
        check("pre_reset_commit", 32'(commit_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_commit_valid", 32'(commit_valid), 32'd0);
        check("mid_rst_commit_val",   commit_val,        32'd0);
        check("mid_rst_commit_tag",   32'(commit_tag),   32'd0);
        check("mid_rst_issue_tag",    32'(issue_tag),    32'd0);
        check("mid_rst_rob_full",     32'(rob_full),     32'd0);
        do_reset();

        // Operand queries: bus forwarding, stored value, idle tag.
        for (int i = 0; i < 5; i++)
            do_issue(5'(i + 1), 0, 0, 0, 32'h700, (i == 3) ? 32'd7 : (i == 4) ? 32'd9 : 32'(32'h10 + i), 0, 0, 1);
        query_Qj = 4'd3; query_Qk = 4'd4;
        alu_valid = 1'b1; alu_tag = 4'd3; alu_val = 32'd7;
        #1;
        check("q_alu_Rj", 32'(query_Rj), 32'd1);
        check("q_alu_Vj", query_Vj,      32'd7);
        check("q_idle_Rk", 32'(query_Rk), 32'd0);
        check("q_idle_Vk", query_Vk,      32'd0);
        step();
        alu_valid = 1'b0;
        lsb_valid = 1'b1; lsb_tag = 4'd4; lsb_val = 32'd9;
        #1;
        check("q_stored_Rj", 32'(query_Rj), 32'd1);
        check("q_stored_Vj", query_Vj,      32'd7);
        check("q_lsb_Rk",    32'(query_Rk), 32'd1);
        check("q_lsb_Vk",    query_Vk,      32'd9);
        step();
        lsb_valid = 1'b0;
        #1 check("q_stored_Vk", query_Vk, 32'd9);
        writeback(1, 0, 1, 1);
        writeback(1, 2, 0, 0);
        wait_drain(20);

        // Mispredicted branch at tag 2 flushes the younger entry.
        do_reset();
        do_issue(5'd6, 0, 0, 0, 32'h1F8, 32'h60, 0, 0, 1);
        do_issue(5'd7, 0, 0, 0, 32'h1FC, 32'h70, 0, 0, 1);
        do_issue(5'd0, 1, 0, 0, 32'h200, 32'h0,  1, 32'h1000, 1);
        do_issue(5'd8, 0, 0, 0, 32'h204, 32'h80, 0, 0, 0);
        writeback(1, 2, 1, 3);
        writeback(1, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (rollback) break;
        end
        check("rollback_seen", 32'(rollback), 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1 check("flush_tag", 32'(issue_tag), 32'd0);
        step();
        issue_valid = 1'b0;
        #1 check("issue_during_rollback", 32'(issue_tag), 32'd0);
        exp_tail = 0;
        do_issue(5'd9, 0, 0, 0, 32'h1000, 32'h90, 0, 0, 1);
        writeback(1, 0, 0, 0);
        wait_drain(10);

        // Store retirement gated by rdy.
        do_issue(5'd0, 0, 1, 0, 32'h300, 32'h77, 0, 0, 1);
        rdy = 1'b0;
        lsb_valid = 1'b1; lsb_tag = 4'(exp_tail - 1); lsb_val = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frozen_store", 32'(commit_store), 32'd0);
            check("frozen_tail",  32'(issue_tag),    32'(exp_tail));
        end
        rdy = 1'b1; lsb_valid = 1'b0; issue_valid = 1'b0;
        step();
        check("store_not_ready", 32'(commit_store), 32'd0);
        writeback(0, 0, 1, (exp_tail + 15) % 16);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy_low_hold", 32'(commit_store), 32'd0);
        end
        rdy = 1'b1;
        wait_drain(10);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
